// File: rtl/acc_seq_pkg.sv
// -----------------------------------------------------------------------------
// acc_seq_pkg
// Shared definitions for the operand accumulator sequencer:
//   - operand / accumulator / index widths and run length
//   - controller state encoding
//   - operand zero-extension helper used by the add/sub unit
// -----------------------------------------------------------------------------
package acc_seq_pkg;

    localparam int DATA_W    = 9;   // operand width (unsigned)
    localparam int ACC_W     = 13;  // accumulator / result width
    localparam int N_ENTRIES = 16;  // operands consumed per run
    localparam int ADDR_W    = 4;   // operand index width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Operands are unsigned, so widening to the accumulator is a plain
    // zero extension.
    function automatic logic [ACC_W-1:0] zext_operand(input logic [DATA_W-1:0] d);
        return {{(ACC_W-DATA_W){1'b0}}, d};
    endfunction

endpackage

// File: rtl/acc_datapath.sv
// -----------------------------------------------------------------------------
// acc_datapath
// Accumulator register with a single add/subtract unit.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : synchronous clear of the accumulator (wins over en)
//   en           : apply operand this cycle
//   sub          : 0 = acc + operand, 1 = acc - operand (mod 2^ACC_W)
//   operand      : unsigned DATA_W operand
//   acc          : current accumulator value
//   borrow       : the subtraction requested this cycle would go below zero
// -----------------------------------------------------------------------------
module acc_datapath
    import acc_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              sub,
    input  logic [DATA_W-1:0] operand,
    output logic [ACC_W-1:0]  acc,
    output logic              borrow
);

    logic [ACC_W-1:0] opnd_ext;

    assign opnd_ext = zext_operand(operand);

    // Borrow is only meaningful in subtract mode; the controller qualifies
    // it with an accepted beat before making it sticky.
    assign borrow = sub && (opnd_ext > acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sub ? (acc - opnd_ext) : (acc + opnd_ext);
        end
    end

endmodule

// File: rtl/acc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// acc_seq_ctrl
// Sequencing controller for the operand accumulator. A start in IDLE clears
// the accumulator, then exactly N_ENTRIES operands are fetched over a
// valid/ready stream (addressed through rd_addr) and added or subtracted.
// The final sum is presented on result with a one-cycle result_valid pulse.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start, op_sub : begin a run / select subtract mode (sampled in IDLE)
//   abort         : cancel a run in CLEAR or ACCUM
//   in_valid, in_data, in_ready : operand stream handshake
//   rd_addr       : index of the operand currently requested
//   busy          : run in progress (CLEAR or ACCUM)
//   result, result_valid : final sum and its one-cycle strobe
//   underflow     : a subtraction borrowed during the current/last run
// -----------------------------------------------------------------------------
module acc_seq_ctrl
    import acc_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op_sub,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    output logic              underflow
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ENTRIES - 1);

    state_t            state;
    state_t            state_nxt;
    logic              op_sub_q;
    logic [ADDR_W-1:0] idx;
    logic [ACC_W-1:0]  result_q;
    logic              underflow_q;

    logic              clr;
    logic              beat;
    logic              last_beat;
    logic [ACC_W-1:0]  acc;
    logic              borrow;

    // Abort squashes both the CLEAR side effects and any beat in flight, so
    // underflow/acc/idx are left exactly as they were.
    assign clr       = (state == ST_CLEAR) && !abort;
    assign in_ready  = (state == ST_ACCUM) && !abort;
    assign beat      = in_ready && in_valid;
    assign last_beat = beat && (idx == LAST_IDX);

    acc_datapath u_datapath (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .en      (beat),
        .sub     (op_sub_q),
        .operand (in_data),
        .acc     (acc),
        .borrow  (borrow)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_CLEAR;
            ST_CLEAR: state_nxt = abort ? ST_IDLE : ST_ACCUM;
            ST_ACCUM: begin
                if (abort)          state_nxt = ST_IDLE;
                else if (last_beat) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_sub_q    <= 1'b0;
            idx         <= '0;
            result_q    <= '0;
            underflow_q <= 1'b0;
        end else begin
            state <= state_nxt;

            if ((state == ST_IDLE) && start) begin
                op_sub_q <= op_sub;
            end

            // idx wraps to 0 naturally on the last beat since LAST_IDX is all
            // ones in ADDR_W bits.
            if (clr) begin
                idx <= '0;
            end else if (beat) begin
                idx <= idx + 1'b1;
            end

            if (clr) begin
                underflow_q <= 1'b0;
            end else if (beat && borrow) begin
                underflow_q <= 1'b1;
            end

            if (state == ST_DONE) begin
                result_q <= acc;
            end
        end
    end

    // During DONE the accumulator already holds the final sum; forwarding it
    // lets result and result_valid appear in the same cycle, after which the
    // captured copy holds it until the next run's DONE.
    assign result_valid = (state == ST_DONE);
    assign result       = result_valid ? acc : result_q;
    assign busy         = (state == ST_CLEAR) || (state == ST_ACCUM);
    assign rd_addr      = idx;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
module tb_acc_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_sub;
    logic        abort;
    logic        in_valid;
    logic [8:0]  in_data;
    logic        in_ready;
    logic [3:0]  rd_addr;
    logic        busy;
    logic [12:0] result;
    logic        result_valid;
    logic        underflow;

    int n_tests = 0;
    int n_fail  = 0;

    acc_seq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op_sub       (op_sub),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .rd_addr      (rd_addr),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        sub;
        logic [8:0]  base;
        logic        ramp;        // data = beat+1 instead of base
        logic        toggle;      // in_valid alternates 1/0
        logic        poke_start;  // pulse start (subtract) mid-run
        logic        abort_start; // abort high together with start in IDLE
        int          exp_lat;
        logic [12:0] exp_res;
        logic        exp_uf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      32'(busy),         32'd0);
        check({tag, "_in_ready"},  32'(in_ready),     32'd0);
        check({tag, "_rd_addr"},   32'(rd_addr),      32'd0);
        check({tag, "_result"},    32'(result),       32'd0);
        check({tag, "_res_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_underflow"}, 32'(underflow),    32'd0);
    endtask

    // Runs one accumulation; returns the cycle (relative to the start edge)
    // in which result_valid was seen, or 0 if it never came.
    task automatic do_run(input vec_t v, output int lat);
        int beats;
        lat   = 0;
        beats = 0;
        @(negedge clk);
        start    = 1'b1;
        op_sub   = v.sub;
        abort    = v.abort_start;
        in_valid = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start  = 1'b0;
            op_sub = 1'b0;
            abort  = 1'b0;
            if (v.poke_start && c == 6) begin
                start  = 1'b1;
                op_sub = 1'b1;
            end
            if (c == 1) begin
                check("clear_busy",     32'(busy),     32'd1);
                check("clear_in_ready", 32'(in_ready), 32'd0);
            end
            if (result_valid) begin
                lat = c;
                break;
            end
            in_valid = v.toggle ? ((c % 2) == 0) : 1'b1;
            in_data  = v.ramp ? 9'(beats + 1) : v.base;
            if (in_ready && in_valid && beats < 16) begin
                check("rd_addr_beat", 32'(rd_addr), 32'(beats));
                beats++;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        int lat;
        int beats;
        int seen;
        logic [12:0] prior;

        //            sub base ramp tog poke abst lat  res   uf
        vecs[0] = '{1'b0, 9'd0,   1'b1, 1'b0, 1'b0, 1'b0, 18, 13'd136,  1'b0};
        vecs[1] = '{1'b0, 9'd511, 1'b0, 1'b0, 1'b0, 1'b0, 18, 13'd8176, 1'b0};
        vecs[2] = '{1'b1, 9'd1,   1'b0, 1'b0, 1'b0, 1'b0, 18, 13'd8176, 1'b1};
        vecs[3] = '{1'b1, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 18, 13'd0,    1'b0};
        vecs[4] = '{1'b0, 9'd5,   1'b0, 1'b1, 1'b0, 1'b0, 33, 13'd80,   1'b0};
        vecs[5] = '{1'b1, 9'd0,   1'b1, 1'b0, 1'b0, 1'b0, 18, 13'd8056, 1'b1};
        vecs[6] = '{1'b0, 9'd7,   1'b0, 1'b0, 1'b1, 1'b0, 18, 13'd112,  1'b0};
        vecs[7] = '{1'b0, 9'd3,   1'b0, 1'b0, 1'b0, 1'b1, 18, 13'd48,   1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        op_sub   = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_run(vecs[i], lat);
            check($sformatf("v%0d_latency", i),   32'(lat),       32'(vecs[i].exp_lat));
            check($sformatf("v%0d_result", i),    32'(result),    32'(vecs[i].exp_res));
            check($sformatf("v%0d_underflow", i), 32'(underflow), 32'(vecs[i].exp_uf));
            check($sformatf("v%0d_done_busy", i), 32'(busy),      32'd0);
            @(negedge clk);
            check($sformatf("v%0d_pulse_end", i), 32'(result_valid), 32'd0);
            check($sformatf("v%0d_rd_wrap", i),   32'(rd_addr),      32'd0);
            check($sformatf("v%0d_res_hold", i),  32'(result),       32'(vecs[i].exp_res));
        end

        // Abort after 5 beats of 10: no result, prior value kept.
        prior = 13'd48;
        @(negedge clk);
        start  = 1'b1;
        op_sub = 1'b0;
        @(posedge clk);
        beats = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (beats == 5) break;
            in_valid = 1'b1;
            in_data  = 9'd10;
            if (in_ready && in_valid) beats++;
        end
        abort = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_busy",   32'(busy),         32'd0);
        check("abort_valid",  32'(result_valid), 32'd0);
        check("abort_result", 32'(result),       32'(prior));
        seen = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        in_valid = 1'b0;
        check("abort_no_valid", 32'(seen),   32'd0);
        check("abort_hold",     32'(result), 32'(prior));

        do_run('{1'b0, 9'd2, 1'b0, 1'b0, 1'b0, 1'b0, 18, 13'd32, 1'b0}, lat);
        check("post_abort_lat", 32'(lat),    32'd18);
        check("post_abort_res", 32'(result), 32'd32);

        // Reset in the middle of ACCUM.
        @(negedge clk);
        start  = 1'b1;
        op_sub = 1'b1;
        @(posedge clk);
        beats = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start  = 1'b0;
            op_sub = 1'b0;
            if (beats == 3) break;
            in_valid = 1'b1;
            in_data  = 9'd9;
            if (in_ready && in_valid) beats++;
        end
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_rst");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (result_valid || busy) seen++;
        end
        in_valid = 1'b0;
        check("post_rst_quiet", 32'(seen), 32'd0);

        do_run(vecs[0], lat);
        check("fresh_lat", 32'(lat),       32'd18);
        check("fresh_res", 32'(result),    32'd136);
        check("fresh_uf",  32'(underflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
